// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared constants for the PUF challenge sequencer: FSM encodings, vote count and default widths.
// Optional feature macro used by the top: PUF_MAJORITY_VOTE_EN.
package puf_challenge_sequencer_pkg;

    localparam int DEF_IN_WIDTH  = 128;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_SLICE_W   = 8;
    localparam int DEF_CNT_WIDTH = 16;

    localparam int MAJ_EVALS = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_FIRE   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_SAMPLE = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    typedef struct packed {
        logic [15:0] settle;
        logic [15:0] sample;
    } puf_timing_t;

endpackage

// File: rtl/puf_delay_counter.sv
// Down-counter shared by the settle and sample phases; zero flags the last cycle of a phase.
module puf_delay_counter
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 dec,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign zero = (value_q == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Walks a latched challenge one slice at a time through an arbiter PUF and collects one bit per slice.
// Define PUF_MAJORITY_VOTE_EN to evaluate each slice three times and keep the majority bit.
module puf_challenge_sequencer
    import puf_challenge_sequencer_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SLICE_W   = DEF_SLICE_W,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [IN_WIDTH-1:0]  dataIn,
    input  logic [15:0]          opA,
    input  logic [15:0]          opB,
    output logic                 done,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] dataOut,
    output logic [SLICE_W-1:0]   puf_challenge,
    output logic                 puf_fire,
    input  logic                 puf_response
);

    localparam int IDX_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_WIDTH - 1);

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IN_WIDTH-1:0]  chal_q, chal_d;
    puf_timing_t          timing_q, timing_d;
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [SLICE_W-1:0]   challenge_q, challenge_d;

    logic                 cnt_load;
    logic                 cnt_dec;
    logic [CNT_WIDTH-1:0] cnt_value;
    logic                 cnt_zero;
    logic                 bit_done;
    logic                 bit_val;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [1:0] REP_LAST = 2'(MAJ_EVALS - 1);
    logic [1:0] rep_q, rep_d;
    logic [1:0] ones_q, ones_d;
    logic [1:0] ones_sum;
`endif

    logic [SLICE_W-1:0] slices [OUT_WIDTH];

    for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_slice
        assign slices[g] = chal_q[g*SLICE_W +: SLICE_W];
    end

    puf_delay_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_delay (
        .clk        (clk),
        .rst        (reset),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (cnt_value),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chal_d      = chal_q;
        timing_d    = timing_q;
        data_out_d  = data_out_q;
        challenge_d = challenge_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_value   = '0;
        bit_done    = 1'b1;
        bit_val     = puf_response;
`ifdef PUF_MAJORITY_VOTE_EN
        rep_d    = rep_q;
        ones_d   = ones_q;
        ones_sum = ones_q + {1'b0, puf_response};
`endif

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    chal_d          = dataIn;
                    timing_d.settle = opA;
                    timing_d.sample = opB;
                    idx_d           = '0;
                    data_out_d      = '0;
`ifdef PUF_MAJORITY_VOTE_EN
                    rep_d  = '0;
                    ones_d = '0;
`endif
                    state_d = S_LOAD;
                end
            end
            // Each delay phase lasts exactly op cycles, so a zero op skips the phase entirely.
            S_LOAD: begin
                challenge_d = slices[idx_q];
                if (timing_q.settle == '0) begin
                    state_d = S_FIRE;
                end else begin
                    cnt_load  = 1'b1;
                    cnt_value = CNT_WIDTH'(timing_q.settle - 16'd1);
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_zero) state_d = S_FIRE;
                else          cnt_dec = 1'b1;
            end
            S_FIRE: begin
                if (timing_q.sample == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_load  = 1'b1;
                    cnt_value = CNT_WIDTH'(timing_q.sample - 16'd1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_zero) state_d = S_SAMPLE;
                else          cnt_dec = 1'b1;
            end
            S_SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                bit_done = (rep_q == REP_LAST);
                bit_val  = (ones_sum >= 2'd2);
                if (bit_done) begin
                    rep_d  = '0;
                    ones_d = '0;
                end else begin
                    rep_d  = rep_q + 2'd1;
                    ones_d = ones_sum;
                end
`endif
                if (!bit_done) begin
                    state_d = S_LOAD;
                end else begin
                    data_out_d[idx_q] = bit_val;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            chal_q      <= '0;
            timing_q    <= '0;
            data_out_q  <= '0;
            challenge_q <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            rep_q  <= '0;
            ones_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            chal_q      <= chal_d;
            timing_q    <= timing_d;
            data_out_q  <= data_out_d;
            challenge_q <= challenge_d;
`ifdef PUF_MAJORITY_VOTE_EN
            rep_q  <= rep_d;
            ones_q <= ones_d;
`endif
        end
    end

    assign done          = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign puf_fire      = (state_q == S_FIRE);
    assign dataOut       = data_out_q;
    assign puf_challenge = challenge_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: vector table plus hand sequences, scoreboard checked on done.
// The PUF model answers the XOR of the applied slice; in vote builds it inverts every 2nd of 3 samples.
module tb_puf_challenge_sequencer;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int EVALS = 3;
`else
    localparam int EVALS = 1;
`endif

    typedef struct {
        logic [127:0] din;
        logic [15:0]  a;
        logic [15:0]  b;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         trigger;
    logic [127:0] dataIn;
    logic [15:0]  opA;
    logic [15:0]  opB;
    logic         done;
    logic         busy;
    logic [15:0]  dataOut;
    logic [7:0]   puf_challenge;
    logic         puf_fire;
    logic         puf_response;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int dones_seen = 0;
    int run_id = 0;
    int per_exp = 0;
    int run_acc = 0;
    int run_a = 0;
    int bad_base = 0;
    int last_run = -1;
    int fires_in_run = 0;
    int first_fire_cyc = 0;
    int last_fire_cyc = 0;
    int bad_intv = 0;
    exp_t sb[$];
    exp_t mon_e;

    puf_challenge_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .dataIn        (dataIn),
        .opA           (opA),
        .opB           (opB),
        .done          (done),
        .busy          (busy),
        .dataOut       (dataOut),
        .puf_challenge (puf_challenge),
        .puf_fire      (puf_fire),
        .puf_response  (puf_response)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    assign puf_response = (^puf_challenge) ^ ((EVALS == 3) && (((fires_in_run - 1) % 3) == 1));

    function automatic logic [15:0] model(input logic [127:0] d);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = ^d[i*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Fire tracker: per-run fire count, first fire time and spacing between fires.
    always @(negedge clk) begin
        if (puf_fire === 1'b1) begin
            if (run_id != last_run) begin
                last_run       = run_id;
                fires_in_run   = 1;
                first_fire_cyc = cyc;
            end else begin
                fires_in_run++;
                if (cyc - last_fire_cyc != per_exp) bad_intv++;
            end
            last_fire_cyc = cyc;
        end
    end

    // Scoreboard consumer: every done must match the oldest outstanding run.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            dones_seen++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1, required no done (nothing outstanding)");
            end else begin
                mon_e = sb.pop_front();
                chk("dataOut", dataOut, mon_e.data);
                chk("done_latency", cyc - mon_e.acc + 1, mon_e.lat);
                chk("busy_in_done", busy, 1);
            end
        end
    end

    task automatic note_accept(input logic [127:0] d, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        run_id++;
        per_exp  = 3 + int'(a) + int'(b);
        run_acc  = cyc;
        run_a    = int'(a);
        bad_base = bad_intv;
        e.data = model(d);
        e.lat  = EVALS * 16 * per_exp + 1;
        e.acc  = cyc;
        sb.push_back(e);
    endtask

    task automatic start(input logic [127:0] d, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dataIn  = d;
        opA     = a;
        opB     = b;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        note_accept(d, a, b);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", bound);
        end
    endtask

    task automatic recover();
        sb.delete();
        trigger = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic finish_run();
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("busy_drops", busy, 0);
        chk("fire_run", last_run, run_id);
        chk("fire_count", fires_in_run, EVALS * 16);
        chk("fire_spacing", bad_intv - bad_base, 0);
        chk("first_fire_cycle", first_fire_cyc - run_acc + 1, 2 + run_a);
    endtask

    task automatic run_full(input logic [127:0] d, input logic [15:0] a, input logic [15:0] b);
        bit seen;
        start(d, a, b);
        wait_done(EVALS * 16 * (3 + int'(a) + int'(b)) + 20, seen);
        if (seen) finish_run();
        else      recover();
    endtask

    initial begin
        vec_t        vt[6];
        bit          seen;
        int          d0;
        int          k;
        logic [15:0] mask;

        vt[0] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 16'd0, 16'd0};
        vt[1] = '{128'h01, 16'd3, 16'd2};
        vt[2] = '{128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 16'd1, 16'd0};
        vt[3] = '{{8{16'hA5C3}}, 16'd0, 16'd4};
        vt[4] = '{{128{1'b1}}, 16'd2, 16'd1};
        vt[5] = '{128'h80000000_00000000_00000000_00000001, 16'd0, 16'd1};

        reset   = 1'b1;
        trigger = 1'b0;
        dataIn  = '0;
        opA     = '0;
        opB     = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_challenge", puf_challenge, 0);
        chk("rst_fire", puf_fire, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_full(vt[i].din, vt[i].a, vt[i].b);

        // Second trigger mid-run with other operands must be ignored, and must not queue a run.
        start(vt[2].din, vt[2].a, vt[2].b);
        repeat (10) @(negedge clk);
        dataIn  = vt[3].din;
        opA     = 16'd7;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done(EVALS * 16 * 4 + 20, seen);
        if (seen) finish_run();
        else      recover();
        d0 = dones_seen;
        repeat (30) @(negedge clk);
        chk("no_queued_done", dones_seen, d0);
        chk("no_queued_busy", busy, 0);

        // Reset in cycle 20 (a fire cycle) aborts the run on the same edge.
        start(vt[0].din, 16'd0, 16'd0);
        repeat (19) @(posedge clk);
        #2;
        mask = 16'((1 << (18 / (3 * EVALS))) - 1);
        chk("fire_before_abort", puf_fire, 1);
        chk("partial_dataOut", dataOut, model(vt[0].din) & mask);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dataOut", dataOut, 0);
        chk("abort_fire", puf_fire, 0);
        sb.delete();
        d0 = dones_seen;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("no_done_after_abort", dones_seen, d0);
        run_full(vt[1].din, vt[1].a, vt[1].b);

        // Operand changes one cycle after accept have no effect.
        start(vt[2].din, 16'd2, 16'd1);
        @(negedge clk);
        dataIn = ~vt[2].din;
        opA    = 16'd5;
        opB    = 16'd3;
        wait_done(EVALS * 16 * 6 + 20, seen);
        if (seen) finish_run();
        else      recover();

        // Trigger held from the DONE cycle: ignored there, accepted one cycle later.
        start(vt[5].din, 16'd0, 16'd0);
        wait_done(EVALS * 16 * 3 + 20, seen);
        if (seen) begin
            dataIn  = vt[1].din;
            opA     = 16'd3;
            opB     = 16'd2;
            trigger = 1'b1;
            @(posedge clk);
            #1;
            chk("trigger_in_done_ignored", busy, 0);
            @(posedge clk);
            #1;
            trigger = 1'b0;
            chk("trigger_after_done_accepted", busy, 1);
            note_accept(vt[1].din, 16'd3, 16'd2);
            wait_done(EVALS * 16 * 8 + 20, seen);
            if (seen) finish_run();
            else      recover();
        end else begin
            recover();
        end

        // Full-scale settle count: first fire lands 65535 extra cycles after LOAD, then abort.
        start(vt[1].din, 16'hFFFF, 16'd0);
        k = 0;
        while (k < 65600 && puf_fire !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        chk("max_settle_first_fire", cyc - run_acc + 1, 65537);
        recover();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
